// File: rtl/audio_pkg.sv
// Shared definitions for the tone sequencer and the audio-block interface.
package audio_pkg;

    localparam int unsigned COLOR_W  = 3;
    localparam int unsigned SYS_FREQ = 50_000_000;

    localparam logic [COLOR_W-1:0] COL_0   = 3'd0;
    localparam logic [COLOR_W-1:0] COL_1   = 3'd1;
    localparam logic [COLOR_W-1:0] COL_2   = 3'd2;
    localparam logic [COLOR_W-1:0] COL_3   = 3'd3;
    localparam logic [COLOR_W-1:0] COL_ERR = 3'd4;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        LOAD_ON,
        TONE,
        LOAD_OFF,
        GAP,
        ERR_ON,
        ERR_TONE
    } seq_state_t;

endpackage

// File: rtl/tone_sequencer_if.sv
// Game-FSM <-> tone_sequencer bundle, including the audio-block drive lines.
// TONE_SEQ_ERROR_TONE_EN adds the err_req request line.
interface tone_sequencer_if;
    import audio_pkg::*;

    logic               push;
    logic [COLOR_W-1:0] push_color;
    logic               full;
    logic               empty;
    logic               start;
    logic               abort;
    logic               busy;
    logic               done;
    logic               play_audio;
    logic [COLOR_W-1:0] color;
    logic               on_off;
`ifdef TONE_SEQ_ERROR_TONE_EN
    logic               err_req;
`endif

    modport master (
        output push, push_color, start, abort,
`ifdef TONE_SEQ_ERROR_TONE_EN
        output err_req,
`endif
        input  full, empty, busy, done, play_audio, color, on_off
    );

    modport slave (
        input  push, push_color, start, abort,
`ifdef TONE_SEQ_ERROR_TONE_EN
        input  err_req,
`endif
        output full, empty, busy, done, play_audio, color, on_off
    );

endinterface

// File: rtl/tone_sequencer_fifo.sv
// color_fifo: DEPTH x COLOR_W synchronous FIFO with flush; pointers carry one
// extra wrap bit so full/empty are distinguished without a counter.
module color_fifo
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [COLOR_W-1:0] push_data,
    input  logic               pop,
    input  logic               flush,
    output logic [COLOR_W-1:0] head,
    output logic               full,
    output logic               empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]        wr_ptr;
    logic [AW:0]        rd_ptr;
    logic [COLOR_W-1:0] mem [DEPTH];
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign head  = mem[rd_ptr[AW-1:0]];
    assign wr_en = push && !full && !flush;
    assign rd_en = pop && !empty && !flush;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/tone_sequencer.sv
// Plays queued Simon colours as timed on/off strobes into the audio block.
// Optional error tone enabled by defining TONE_SEQ_ERROR_TONE_EN.
module tone_sequencer
    import audio_pkg::*;
#(
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned TONE_CYCLES = 25_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000,
    parameter int unsigned CNT_W       = 26,
    parameter int unsigned ERR_CYCLES  = 50_000_000
) (
    input logic             clock,
    input logic             reset,
    tone_sequencer_if.slave bus
);

    seq_state_t         state;
    logic [CNT_W-1:0]   timer;
    logic               play_r;
    logic               on_off_r;
    logic [COLOR_W-1:0] color_r;
    logic               busy_r;
    logic               done_r;

    logic               fifo_full;
    logic               fifo_empty;
    logic [COLOR_W-1:0] head;
    logic               push_ok;
    logic               err_go;
    logic               abort_go;
    logic               flush;
    logic               start_go;
    logic               next_go;
    logic               pop;
    logic               expired;

    function automatic logic [CNT_W-1:0] load_value(input seq_state_t s);
        case (s)
            LOAD_ON:  return CNT_W'(TONE_CYCLES - 1);
            LOAD_OFF: return CNT_W'(GAP_CYCLES - 1);
            ERR_TONE: return CNT_W'(ERR_CYCLES - 1);
            default:  return '0;
        endcase
    endfunction

`ifdef TONE_SEQ_ERROR_TONE_EN
    assign err_go = bus.err_req && (state != INIT) && (state != ERR_ON) && (state != ERR_TONE);
`else
    assign err_go = 1'b0;
`endif

    assign expired  = (timer == '0);
    assign push_ok  = bus.push && (bus.push_color <= COL_3);
    assign abort_go = bus.abort && (state != INIT) && (state != IDLE) && !err_go;
    assign flush    = (bus.abort && (state != INIT)) || err_go;
    // A trailing silence strobe leaves play_r high in IDLE; start waits a cycle
    // so play_audio is never asserted twice in a row.
    assign start_go = (state == IDLE) && bus.start && !fifo_empty && !play_r
                      && !bus.abort && !err_go;
    assign next_go  = (state == GAP) && expired && !fifo_empty && !bus.abort && !err_go;
    assign pop      = start_go || next_go;

    color_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push_ok),
        .push_data (bus.push_color),
        .pop       (pop),
        .flush     (flush),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= INIT;
            timer    <= '0;
            play_r   <= 1'b0;
            on_off_r <= 1'b0;
            color_r  <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            play_r <= 1'b0;
            done_r <= 1'b0;
            if (timer != '0) timer <= timer - 1'b1;

`ifdef TONE_SEQ_ERROR_TONE_EN
            if (err_go) begin
                busy_r <= 1'b1;
                if (play_r) begin
                    state <= ERR_ON;
                end else begin
                    play_r   <= 1'b1;
                    on_off_r <= 1'b1;
                    color_r  <= COL_ERR;
                    timer    <= load_value(ERR_TONE);
                    state    <= ERR_TONE;
                end
            end else
`endif
            // An abort landing on a strobe cycle cannot strobe again next cycle:
            // an on strobe is silenced via INIT one cycle later, an off strobe needs nothing.
            if (abort_go) begin
                if (!play_r) begin
                    play_r   <= 1'b1;
                    on_off_r <= 1'b0;
                    state    <= IDLE;
                end else if (on_off_r) begin
                    state <= INIT;
                end else begin
                    state <= IDLE;
                end
            end else begin
                case (state)
                    INIT: begin
                        play_r   <= 1'b1;
                        on_off_r <= 1'b0;
                        color_r  <= COL_0;
                        state    <= IDLE;
                    end
                    IDLE: begin
                        busy_r <= 1'b0;
                        if (start_go) begin
                            busy_r   <= 1'b1;
                            play_r   <= 1'b1;
                            on_off_r <= 1'b1;
                            color_r  <= head;
                            timer    <= load_value(LOAD_ON);
                            state    <= LOAD_ON;
                        end
                    end
                    LOAD_ON: state <= TONE;
                    TONE: begin
                        if (expired) begin
                            play_r   <= 1'b1;
                            on_off_r <= 1'b0;
                            timer    <= load_value(LOAD_OFF);
                            state    <= LOAD_OFF;
                        end
                    end
                    LOAD_OFF: state <= GAP;
                    GAP: begin
                        if (expired) begin
                            if (next_go) begin
                                play_r   <= 1'b1;
                                on_off_r <= 1'b1;
                                color_r  <= head;
                                timer    <= load_value(LOAD_ON);
                                state    <= LOAD_ON;
                            end else begin
                                done_r <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
`ifdef TONE_SEQ_ERROR_TONE_EN
                    ERR_ON: begin
                        play_r   <= 1'b1;
                        on_off_r <= 1'b1;
                        color_r  <= COL_ERR;
                        timer    <= load_value(ERR_TONE);
                        state    <= ERR_TONE;
                    end
                    ERR_TONE: begin
                        if (expired) begin
                            play_r   <= 1'b1;
                            on_off_r <= 1'b0;
                            state    <= IDLE;
                        end
                    end
`endif
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.full       = fifo_full;
    assign bus.empty      = fifo_empty;
    assign bus.busy       = busy_r;
    assign bus.done       = done_r;
    assign bus.play_audio = play_r;
    assign bus.color      = color_r;
    assign bus.on_off     = on_off_r;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with short timings (TONE=4, GAP=2, DEPTH=4, ERR=6).
module tb_tone_sequencer;
    import audio_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    tone_sequencer_if bus();

    tone_sequencer #(
        .DEPTH       (4),
        .TONE_CYCLES (4),
        .GAP_CYCLES  (2),
        .CNT_W       (8),
        .ERR_CYCLES  (6)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_one(input logic [2:0] c);
        bus.push       = 1'b1;
        bus.push_color = c;
        tick();
        bus.push       = 1'b0;
    endtask

    task automatic test_reset();
        bus.push = 1'b0; bus.push_color = '0; bus.start = 1'b0; bus.abort = 1'b0;
`ifdef TONE_SEQ_ERROR_TONE_EN
        bus.err_req = 1'b0;
`endif
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if ({bus.play_audio, bus.on_off, bus.busy, bus.done, bus.full, bus.empty, bus.color} !== 9'b000001_000) begin
            miscompares++;
            $display("FAIL reset_state: got %b want %b",
                     {bus.play_audio, bus.on_off, bus.busy, bus.done, bus.full, bus.empty, bus.color}, 9'b000001_000);
        end
        reset = 1'b0;
        tick();
        vectors++;
        if ({bus.play_audio, bus.on_off, bus.color} !== 5'b10_000) begin
            miscompares++;
            $display("FAIL init_strobe: got %b want %b", {bus.play_audio, bus.on_off, bus.color}, 5'b10_000);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({bus.play_audio, bus.busy, bus.empty} !== 3'b001) begin
                miscompares++;
                $display("FAIL post_init_idle[%0d]: got %b want %b", i, {bus.play_audio, bus.busy, bus.empty}, 3'b001);
            end
        end
    endtask

    task automatic test_playback();
        logic [2:0] cols [3];
        logic       ep, eo, ed, eb;
        logic [2:0] ec;
        cols = '{3'd2, 3'd0, 3'd3};
        for (int k = 0; k < 3; k++) push_one(cols[k]);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 21; i++) begin
            ep = (i inside {1, 5, 7, 11, 13, 17});
            eo = (i inside {1, 7, 13});
            ec = (i <= 5) ? 3'd2 : (i <= 11) ? 3'd0 : 3'd3;
            ed = (i == 19);
            eb = (i <= 19);
            vectors++;
            if (bus.play_audio !== ep) begin
                miscompares++;
                $display("FAIL play t+%0d: play_audio got %b want %b", i, bus.play_audio, ep);
            end
            if (ep) begin
                vectors++;
                if ({bus.on_off, bus.color} !== {eo, ec}) begin
                    miscompares++;
                    $display("FAIL strobe t+%0d: on_off/color got %b/%0d want %b/%0d", i, bus.on_off, bus.color, eo, ec);
                end
            end
            vectors++;
            if ({bus.done, bus.busy} !== {ed, eb}) begin
                miscompares++;
                $display("FAIL status t+%0d: done/busy got %b%b want %b%b", i, bus.done, bus.busy, ed, eb);
            end
            tick();
        end
    endtask

    task automatic test_full();
        int unsigned ons = 0;
        int unsigned dones = 0;
        for (int k = 0; k < 5; k++) begin
            push_one(3'd1);
            vectors++;
            if (bus.full !== (k >= 3)) begin
                miscompares++;
                $display("FAIL full_after_push%0d: got %b want %b", k + 1, bus.full, (k >= 3));
            end
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 26; i++) begin
            if (bus.play_audio && bus.on_off) ons++;
            if (bus.done) dones++;
            tick();
        end
        vectors++;
        if (ons != 4 || dones != 1) begin
            miscompares++;
            $display("FAIL full_playback: tones/done got %0d/%0d want 4/1", ons, dones);
        end
        vectors++;
        if ({bus.busy, bus.empty} !== 2'b01) begin
            miscompares++;
            $display("FAIL full_drained: busy/empty got %b want 01", {bus.busy, bus.empty});
        end
        push_one(3'd6);
        vectors++;
        if (bus.empty !== 1'b1) begin
            miscompares++;
            $display("FAIL bad_color_push: empty got %b want 1", bus.empty);
        end
    endtask

    task automatic test_abort();
        push_one(3'd1); push_one(3'd2); push_one(3'd3);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (8) tick();
        bus.abort = 1'b1; bus.push = 1'b1; bus.push_color = 3'd1;
        tick();
        bus.abort = 1'b0; bus.push = 1'b0;
        vectors++;
        if ({bus.play_audio, bus.on_off, bus.color, bus.empty, bus.busy, bus.done} !== 8'b10_010_110) begin
            miscompares++;
            $display("FAIL abort_strobe: got %b want %b",
                     {bus.play_audio, bus.on_off, bus.color, bus.empty, bus.busy, bus.done}, 8'b10_010_110);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if ({bus.play_audio, bus.busy, bus.done, bus.empty} !== 4'b0001) begin
                miscompares++;
                $display("FAIL abort_after[%0d]: play/busy/done/empty got %b want 0001",
                         i, {bus.play_audio, bus.busy, bus.done, bus.empty});
            end
        end
    endtask

    task automatic test_empty_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if ({bus.play_audio, bus.busy, bus.done} !== 3'b000) begin
                miscompares++;
                $display("FAIL empty_start[%0d]: play/busy/done got %b want 000",
                         i, {bus.play_audio, bus.busy, bus.done});
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic       ep, eo, ed, eb;
        logic [2:0] ec;
        push_one(3'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            bus.push       = (i == 1);
            bus.push_color = 3'd3;
            ep = (i inside {1, 5, 7, 11});
            eo = (i inside {1, 7});
            ec = (i <= 5) ? 3'd1 : 3'd3;
            ed = (i == 13);
            eb = (i <= 13);
            vectors++;
            if ({bus.play_audio, bus.done, bus.busy} !== {ep, ed, eb}) begin
                miscompares++;
                $display("FAIL append t+%0d: play/done/busy got %b want %b",
                         i, {bus.play_audio, bus.done, bus.busy}, {ep, ed, eb});
            end
            if (ep) begin
                vectors++;
                if ({bus.on_off, bus.color} !== {eo, ec}) begin
                    miscompares++;
                    $display("FAIL append_strobe t+%0d: on_off/color got %b/%0d want %b/%0d",
                             i, bus.on_off, bus.color, eo, ec);
                end
            end
            tick();
        end
        bus.push = 1'b0;
    endtask

`ifdef TONE_SEQ_ERROR_TONE_EN
    task automatic test_error_tone();
        logic ep, eb;
        push_one(3'd1); push_one(3'd2);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (5) tick();
        bus.err_req = 1'b1;
        tick();
        bus.err_req = 1'b0;
        for (int i = 7; i <= 16; i++) begin
            bus.err_req = (i == 9);
            ep = (i inside {7, 13});
            eb = (i <= 13);
            vectors++;
            if ({bus.play_audio, bus.busy, bus.done, bus.empty} !== {ep, eb, 1'b0, 1'b1}) begin
                miscompares++;
                $display("FAIL err t+%0d: play/busy/done/empty got %b want %b",
                         i, {bus.play_audio, bus.busy, bus.done, bus.empty}, {ep, eb, 1'b0, 1'b1});
            end
            if (ep) begin
                vectors++;
                if ({bus.on_off, bus.color} !== {(i == 7), 3'd4}) begin
                    miscompares++;
                    $display("FAIL err_strobe t+%0d: on_off/color got %b/%0d want %b/4",
                             i, bus.on_off, bus.color, (i == 7));
                end
            end
            tick();
        end
        bus.err_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_playback();
        test_full();
        test_abort();
        test_empty_start();
        test_back_to_back();
`ifdef TONE_SEQ_ERROR_TONE_EN
        test_error_tone();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
- Queues a Simon-style colour sequence and plays it through the audio tone block.
- Each queued colour becomes a timed tone-on/tone-off strobe pair on the tone block's play_audio/color/on_off inputs, followed by a silent gap.
- Sits between the game FSM (pushes colours, starts/aborts playback) and the audio block.
- Sole owner of the audio block's control inputs.

Parameters:
- DEPTH, 16, colour queue entries (power of two).
- TONE_CYCLES, 25000000, clock cycles from tone-on strobe to tone-off strobe (0.5 s at 50 MHz).
- GAP_CYCLES, 5000000, clock cycles from tone-off strobe to next tone-on strobe or done.
- CNT_W, 26, timer width; must hold max(TONE_CYCLES, GAP_CYCLES, ERR_CYCLES).
- ERR_CYCLES, 50000000, error-tone length (used only with the optional feature).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high reset.
- push  in  1  enqueue push_color this cycle.
- push_color  in  3  colour code 0-3; codes 4-7 are rejected.
- full  out  1  queue holds DEPTH entries.
- empty  out  1  queue holds 0 entries.
- start  in  1  begin playback of queued entries.
- abort  in  1  stop playback, silence audio, flush queue.
- busy  out  1  playback in progress.
- done  out  1  one-cycle pulse when the queue has been fully played.
- play_audio  out  1  one-cycle load strobe to the audio block.
- color  out  3  tone colour to the audio block; valid when play_audio=1.
- on_off  out  1  audio enable to the audio block; valid when play_audio=1.

Behaviour:
- Reset (async): queue empty; full=0, empty=1, busy=0, done=0, play_audio=0, color=0, on_off=0; state=INIT.
- INIT: in the first clock after reset deasserts, issue play_audio=1, on_off=0, color=0. This silences the audio block, whose registers are not reset. Then go to IDLE.
- Queue push:
  - Accepted when push=1, full=0 and push_color<=3.
  - Otherwise dropped silently; no flag.
  - full is sampled before any same-cycle pop, so a push while full is dropped even if a pop occurs in that cycle.
  - Pushes are accepted in every state except the abort cycle; entries appended during playback are played in the same run.
- IDLE:
  - start=1 with empty=0 → LOAD_ON next cycle; busy=1 from that cycle.
  - start with empty=1 is ignored: no busy, no done.
- LOAD_ON: play_audio=1, on_off=1, color=head entry; pop the head; load the timer; → TONE.
- TONE: → LOAD_OFF when the timer expires, so the off strobe falls exactly TONE_CYCLES cycles after the on strobe.
- LOAD_OFF: play_audio=1, on_off=0, color=same colour; load the timer; → GAP.
- GAP: exactly GAP_CYCLES cycles after the off strobe:
  - queue non-empty → LOAD_ON in that cycle;
  - otherwise done=1 for that cycle and → IDLE; busy=0 from the next cycle.
- start while busy is ignored.
- abort (any state except INIT/IDLE; wins over a simultaneous start or timer expiry):
  - next cycle: play_audio=1, on_off=0;
  - queue flushed (a same-cycle push is dropped);
  - → IDLE, busy=0 the cycle after; no done pulse.
- abort in IDLE flushes the queue only; no strobe.
- Timer: down-counter of CNT_W bits loaded with N-1 (N = TONE_CYCLES or GAP_CYCLES); expires at 0; no wrap.
- Queue pointers: log2(DEPTH)+1 bits, wrapping modulo 2*DEPTH.
- play_audio is never high for two consecutive cycles.

Optional Feature:
- Macro: TONE_SEQ_ERROR_TONE_EN.
- With the macro defined:
  - Adds input err_req (1 bit), accepted in any state except INIT. It pre-empts playback and IDLE and has priority over start and abort.
  - Queue is flushed.
  - Next cycle: play_audio=1, on_off=1, color=4 (error tone). ERR_CYCLES later: off strobe, then → IDLE.
  - busy=1 throughout; no done pulse.
  - err_req during the error tone is ignored.
- Without the macro: no err_req port; colour 4 is never emitted.

Decomposition:
- Shared package audio_pkg:
  - COLOR_W=3;
  - colour codes COL_0..COL_3=0-3 and COL_ERR=4;
  - state enum {INIT, IDLE, LOAD_ON, TONE, LOAD_OFF, GAP, ERR_ON, ERR_TONE};
  - SYS_FREQ=50000000.
- One sub-module: color_fifo (DEPTH×3 synchronous FIFO with push/pop/flush, full/empty, async reset).

Test Plan (TONE_CYCLES=4, GAP_CYCLES=2, DEPTH=4):
- Reset release → exactly one play_audio pulse with on_off=0 in the first cycle; then idle, empty=1.
- Push 2,0,3; start at cycle t:
  - on strobes at t+1, t+7, t+13 (colours 2, 0, 3);
  - off strobes at t+5, t+11, t+17;
  - done at t+19; busy low at t+20.
- Push 5 cycles with values 1,1,1,1,1 → full=1 after the 4th; the 5th is dropped; push of 6 when not full is dropped; playback emits 4 tones.
- Abort during TONE of the 2nd of 3 tones → off strobe next cycle, empty=1, no done, busy low one cycle later.
- Start with empty queue → no strobe, busy stays 0, done stays 0.
- With TONE_SEQ_ERROR_TONE_EN and ERR_CYCLES=6: err_req during GAP → next cycle on strobe with color=4; off strobe 6 cycles later; queue empty; no done.
